// File: rtl/game_ctrl.sv
// Cat-Mouse game sequencer: button debounce, IDLE/RUN/PAUSED/OVER FSM, tick gate.
// Define GAME_CTRL_SYNC_EN to add a 2-flop synchroniser ahead of each debouncer.
module game_ctrl_debounce #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic         level;
    logic [W-1:0] cnt;
    logic         deb;
    logic         deb_prev;

`ifdef GAME_CTRL_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    assign level = sync[1];
`else
    assign level = btn;
`endif

    // Release clears at once; only the press edge is filtered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            if (!level) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (&cnt) begin
                deb <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
        end
    end

endmodule

module game_ctrl #(
    parameter int DEBOUNCE_W = 16,
    parameter int TICK_DIV   = 2500000,
    parameter int TICK_W     = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_btn,
    input  logic       reset_btn,
    input  logic       game_over,
    output logic [1:0] state,
    output logic       run,
    output logic       game_tick,
    output logic       clear
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        OVER   = 2'b11
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                pause_press;
    logic                reset_press;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick_wrap;
    logic                stay_run;

    game_ctrl_debounce #(.W(DEBOUNCE_W)) u_pause_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (pause_btn),
        .press (pause_press)
    );

    game_ctrl_debounce #(.W(DEBOUNCE_W)) u_reset_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (reset_btn),
        .press (reset_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            reset_press: begin
                state_d = IDLE;
            end
            game_over && (state_q == RUN): begin
                state_d = OVER;
            end
            pause_press: begin
                unique case (state_q)
                    IDLE:   state_d = RUN;
                    RUN:    state_d = PAUSED;
                    PAUSED: state_d = RUN;
                    OVER:   state_d = OVER;
                endcase
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
    // Counting only on RUN->RUN edges keeps the frozen value intact across a pause.
    assign stay_run  = (state_q == RUN) && (state_d == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
            clear     <= 1'b0;
        end else begin
            if ((state_d == IDLE) || (state_d == OVER)) begin
                tick_cnt <= '0;
            end else if (stay_run) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            end
            game_tick <= stay_run && tick_wrap;
            clear     <= reset_press;
        end
    end

    assign state = state_q;
    assign run   = (state_q == RUN);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (DEBOUNCE_W=4, TICK_DIV=5).
module tb_game_ctrl;

    localparam int DIV = 5;
`ifdef GAME_CTRL_SYNC_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 17;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause_btn;
    logic       reset_btn;
    logic       game_over;
    logic [1:0] state;
    logic       run;
    logic       game_tick;
    logic       clear;

    int total  = 0;
    int passed = 0;
    int tc     = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .DEBOUNCE_W (4),
        .TICK_DIV   (5),
        .TICK_W     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause_btn (pause_btn),
        .reset_btn (reset_btn),
        .game_over (game_over),
        .state     (state),
        .run       (run),
        .game_tick (game_tick),
        .clear     (clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic [1:0] st,
                        input logic tk, input logic cl);
        chk(tag, 32'({state, run, game_tick, clear}),
            32'({st, (st == 2'b01), tk, cl}));
    endtask

    // One RUN cycle with the expected divider phase tracked in tc.
    task automatic run_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            logic t;
            t  = (tc == DIV - 1);
            tc = t ? 0 : tc + 1;
            cyc();
            outs("run", 2'b01, t, 1'b0);
        end
    endtask

    task automatic idle_press();
        pause_btn = 1'b1;
        for (int e = 0; e < LAT; e++) begin
            cyc();
            outs("idle_wait", 2'b00, 1'b0, 1'b0);
        end
        cyc();
        outs("start", 2'b01, 1'b0, 1'b0);
        tc = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        pause_btn = 1'b0;
        reset_btn = 1'b0;
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        outs("in_reset", 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            outs("idle_hold", 2'b00, 1'b0, 1'b0);
        end

        // Start, then hold the button: no repeat press, tick every 5th cycle.
        idle_press();
        run_cyc(40 - LAT - 1);
        pause_btn = 1'b0;
        run_cyc(6);

        // Bounce: never reaches saturation.
        pause_btn = 1'b1;
        run_cyc(10);
        pause_btn = 1'b0;
        run_cyc(1);
        pause_btn = 1'b1;
        run_cyc(10);
        pause_btn = 1'b0;
        run_cyc(6);

        // Pause, then resume from the frozen divider phase.
        pause_btn = 1'b1;
        run_cyc(LAT);
        cyc();
        outs("paused", 2'b10, 1'b0, 1'b0);
        pause_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            outs("paused_hold", 2'b10, 1'b0, 1'b0);
        end
        pause_btn = 1'b1;
        for (int e = 0; e < LAT; e++) begin
            cyc();
            outs("paused_wait", 2'b10, 1'b0, 1'b0);
        end
        cyc();
        outs("resume", 2'b01, 1'b0, 1'b0);
        pause_btn = 1'b0;
        run_cyc(12);

        // game_over and pause press together: OVER.
        pause_btn = 1'b1;
        run_cyc(LAT);
        game_over = 1'b1;
        cyc();
        outs("over", 2'b11, 1'b0, 1'b0);
        game_over = 1'b0;
        pause_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            outs("over_hold", 2'b11, 1'b0, 1'b0);
        end
        pause_btn = 1'b1;
        for (int e = 0; e < LAT + 4; e++) begin
            cyc();
            outs("over_pause", 2'b11, 1'b0, 1'b0);
        end
        pause_btn = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Simultaneous pause and reset: reset wins, clear for one cycle.
        pause_btn = 1'b1;
        reset_btn = 1'b1;
        for (int e = 0; e < LAT; e++) begin
            cyc();
            outs("both_wait", 2'b11, 1'b0, 1'b0);
        end
        cyc();
        outs("clear_on", 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            outs("clear_off", 2'b00, 1'b0, 1'b0);
        end
        pause_btn = 1'b0;
        reset_btn = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Reset asserted mid-press while running.
        idle_press();
        pause_btn = 1'b0;
        run_cyc(6);
        pause_btn = 1'b1;
        run_cyc(10);
        rst_n = 1'b0;
        #1;
        outs("mid_reset", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        outs("mid_reset_hold", 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle_press();
        run_cyc(6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencing controller for the Cat-Mouse design. It debounces the pause and reset push-buttons and turns clean presses into one-cycle events. A four-state game FSM (IDLE/RUN/PAUSED/OVER) consumes those events and gates the movement tick that drives the cat and mouse logic. It sits between the board buttons and the game datapath and replaces per-button debouncer instances.

## Interface

Parameters:
- DEBOUNCE_W, 16: width of each per-button stability counter; a press must be stable for 2^DEBOUNCE_W cycles.
- TICK_DIV, 2500000: cycles between game_tick pulses in RUN; legal range is 2 or more.
- TICK_W, 22: width of the tick divider counter; 2^TICK_W must be at least TICK_DIV.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- pause_btn, input, 1: raw pause button, active-high, asynchronous to clk.
- reset_btn, input, 1: raw game-reset button, active-high, asynchronous to clk.
- game_over, input, 1: synchronous level from the game datapath (cat caught mouse).
- state, output, 2: current state; IDLE=00, RUN=01, PAUSED=10, OVER=11.
- run, output, 1: high exactly when state==RUN.
- game_tick, output, 1: one-cycle movement strobe.
- clear, output, 1: one-cycle pulse instructing the datapath to reinitialise positions and score.

## Operation

- Per-button front end (identical for pause and reset):
  - Optional 2-flop synchroniser.
  - DEBOUNCE_W-bit counter.
  - Debounced level register.
  - Press pulse register.
- Synchronised input low: the counter and the debounced level clear to 0 on the next edge. Release is immediate; there is no release debounce.
- Synchronised input high:
  - The counter increments and saturates at all-ones; it does not wrap.
  - The debounced level is set on the edge where the counter is already all-ones and the input is high.
- Press pulse register is set to debounced & ~debounced_prev, so each press yields exactly one pulse. Holding the button produces no repeat pulses.
- FSM transitions, evaluated each edge, in priority order:
  1. reset press, from any state: go to IDLE and assert clear for 1 cycle. This applies even if already in IDLE.
  2. game_over high while in RUN: go to OVER.
  3. pause press: IDLE→RUN, RUN→PAUSED, PAUSED→RUN. In OVER, pause press is ignored.
  4. Otherwise hold the current state.
- game_over is ignored in IDLE, PAUSED and OVER.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while in RUN.
  - game_tick is registered and high for the cycle after the counter wraps from TICK_DIV-1 to 0.
  - In PAUSED the counter freezes and resumes from the frozen value on return to RUN.
  - The counter clears to 0 on entry to IDLE or OVER.
  - game_tick is never high while state!=RUN.

## Timing

- Reset values while rst_n is low: state=00, run=0, game_tick=0, clear=0. All counters, synchronisers and debounce registers are 0.
- Release of rst_n is synchronised externally; the block needs no internal reset synchroniser.
- Press latency, with the raw button high and stable from edge 0:
  - With SYNC_EN: state updates at edge 2^DEBOUNCE_W+3.
  - Without SYNC_EN: state updates at edge 2^DEBOUNCE_W+1.
- A glitch low at any point before the debounced level sets restarts the count from 0.
- clear asserts on the same edge that state becomes IDLE, and deasserts on the following edge.
- Simultaneous pause and reset presses: reset wins and the pause press is discarded.
- game_over and pause press in the same RUN cycle: the FSM goes to OVER.
- Asserting rst_n low mid-count or mid-press aborts everything immediately; no pulse is emitted after reset.

## Configuration

- GAME_CTRL_SYNC_EN defined: each button passes through a 2-flop synchroniser before its debounce counter; latency is as stated above.
- GAME_CTRL_SYNC_EN undefined: the raw inputs feed the counters directly, saving 2 cycles and 4 flops. This is valid only when the buttons are already synchronous to clk.
- FSM, tick and clear behaviour are identical in both builds.

## Test plan

All scenarios use DEBOUNCE_W=4 and TICK_DIV=5.

1. Reset and IDLE hold: hold rst_n=0 for 3 cycles, then release with no buttons pressed.
   - Required: state=00, run=0, game_tick=0 and clear=0 for 50 cycles.
2. Start and tick cadence (SYNC_EN on): raise pause_btn at edge 0 and hold it for 40 cycles.
   - Required: state=01 from edge 19, with exactly one pause transition.
   - Required: game_tick pulses every 5th cycle thereafter.
3. Bounce rejection: drive pause_btn high 10 cycles, low 1, high 10, low.
   - Required: no state change and no press pulse.
4. Pause freeze: from RUN, apply a second valid pause press.
   - Required: state=10 and game_tick stays 0 while paused.
   - After a third press: state=01, and the first tick arrives at the remaining frozen count, not after a full 5 cycles.
5. Priority:
   - In RUN, assert game_over together with a pause press. Required: state=11.
   - Then apply a pause press. Required: state stays 11.
   - Then apply simultaneous pause and reset presses. Required: state=00, clear high for exactly 1 cycle.
6. Mid-press reset: pull rst_n low at count 10 of a press.
   - Required: all outputs are 0 immediately.
   - After release with the button still held: a full 2^4-cycle count restarts before any state change.
